// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: controller state, display FSM state and lap sizing.
// Imported by lap_buffer and lap_recall_ctrl.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } sw_state_t;

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        HOLD   = 2'd1,
        RECALL = 2'd2
    } disp_state_t;

    localparam int LAP_DEPTH = 8;
    localparam int PTR_W     = $clog2(LAP_DEPTH);

endpackage

// File: rtl/lap_buffer.sv
// Circular lap store with saturating count and chronological read mapping.
// Ports: clk, rstn, clr, wr_en, wr_data, rd_idx (1-based), rd_data, lap_count, full.
module lap_buffer
    import stopwatch_pkg::*;
#(
    parameter int TIME_W = 24,
    parameter int DEPTH  = LAP_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [TIME_W-1:0] wr_data,
    input  logic [CW-1:0]     rd_idx,
    output logic [TIME_W-1:0] rd_data,
    output logic [CW-1:0]     lap_count,
    output logic              full
);

    logic [TIME_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     oldest;
    logic [PW-1:0]     rd_addr;

    assign full    = (lap_count == CW'(DEPTH));
    // Once wrapped, the slot about to be overwritten holds the oldest lap.
    assign oldest  = full ? wr_ptr : '0;
    assign rd_addr = PW'({1'b0, oldest} + rd_idx - CW'(1));
    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_ptr    <= '0;
            lap_count <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (!full)
                lap_count <= lap_count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/lap_recall_ctrl.sv
// Lap capture, display hold and stopped-mode lap browsing for the stopwatch.
// Ports: clk, rstn, state_i, lap_en, time_i, next_n -> disp_time, lap_num,
// lap_count, full, recall_active. Define LAP_SPLIT_EN to store split times.
module lap_recall_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TIME_W      = 24,
    parameter int DEPTH       = LAP_DEPTH,
    parameter int HOLD_CYCLES = 150000000,
    localparam int CW         = $clog2(DEPTH) + 1,
    localparam int HCW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        state_i,
    input  logic              lap_en,
    input  logic [TIME_W-1:0] time_i,
    input  logic              next_n,
    output logic [TIME_W-1:0] disp_time,
    output logic [CW-1:0]     lap_num,
    output logic [CW-1:0]     lap_count,
    output logic              full,
    output logic              recall_active
);

    disp_state_t       fsm;
    logic              prev_next_n;
    logic              next_edge;
    logic              clr;
    logic              cap;
    logic              browse;
    logic [TIME_W-1:0] cap_val;
    logic [TIME_W-1:0] hold_val;
    logic [TIME_W-1:0] rd_data;
    logic [HCW-1:0]    hold_cnt;
    logic [CW-1:0]     new_count;

    assign next_edge = !next_n && prev_next_n;
    assign clr       = (state_i == INIT);
    assign cap       = rstn && lap_en && !clr;
    assign browse    = (state_i == STOP) && next_edge && (lap_count != '0);
    assign new_count = full ? lap_count : lap_count + CW'(1);
    assign recall_active = (fsm == RECALL);

`ifdef LAP_SPLIT_EN
    logic [TIME_W-1:0] last_cap;

    assign cap_val = time_i - last_cap;

    always_ff @(posedge clk) begin
        if (!rstn || clr)
            last_cap <= '0;
        else if (lap_en)
            last_cap <= time_i;
    end
`else
    assign cap_val = time_i;
`endif

    lap_buffer #(
        .TIME_W (TIME_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .wr_en     (cap),
        .wr_data   (cap_val),
        .rd_idx    (lap_num),
        .rd_data   (rd_data),
        .lap_count (lap_count),
        .full      (full)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fsm         <= LIVE;
            disp_time   <= '0;
            lap_num     <= '0;
            hold_val    <= '0;
            hold_cnt    <= '0;
            prev_next_n <= 1'b0;
        end else begin
            prev_next_n <= next_n;
            if (clr) begin
                fsm       <= LIVE;
                lap_num   <= '0;
                disp_time <= time_i;
            end else begin
                unique case (fsm)
                    LIVE:    disp_time <= time_i;
                    HOLD:    disp_time <= hold_val;
                    RECALL:  disp_time <= rd_data;
                    default: disp_time <= time_i;
                endcase
                // A capture outranks browsing; lap_en only comes in RUN.
                if (lap_en) begin
                    fsm      <= HOLD;
                    hold_val <= cap_val;
                    hold_cnt <= HCW'(HOLD_CYCLES - 1);
                    lap_num  <= new_count;
                end else if (fsm != RECALL && browse) begin
                    fsm     <= RECALL;
                    lap_num <= lap_count;
                end else if (fsm == HOLD) begin
                    if (hold_cnt == '0) begin
                        fsm     <= LIVE;
                        lap_num <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HCW'(1);
                    end
                end else if (fsm == RECALL) begin
                    if (state_i != STOP) begin
                        fsm     <= LIVE;
                        lap_num <= '0;
                    end else if (next_edge) begin
                        lap_num <= (lap_num == CW'(1)) ? lap_count
                                                       : lap_num - CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/lap_recall_ctrl.md
Name: lap_recall_ctrl

Overview:
- Sequences the lap-time storage and display-source selection for the stopwatch.
- Captures the running time into a small circular lap buffer on each lap pulse from the main stopwatch controller.
- Freezes the display on the captured lap for a hold period.
- While the stopwatch is stopped, lets the user browse stored laps with a dedicated button. Drives the time value fed to the 7-segment display path.

Parameters:
- TIME_W, 24, width of the binary centisecond time value.
- DEPTH, 8, number of lap entries. Must be a power of 2 and ≥2.
- HOLD_CYCLES, 150000000, clk cycles the display is frozen after a lap capture (3 s at 50 MHz). Must be ≥1.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset. Synchronous, active-low.
- state_i  in  2  stopwatch controller state: INIT=0, RUN=1, STOP=2, LAP=3.
- lap_en  in  1  one-cycle lap capture pulse from the controller.
- time_i  in  TIME_W  live timer value.
- next_n  in  1  browse button, active-low, already synchronised.
- disp_time  out  TIME_W  registered value for display.
- lap_num  out  $clog2(DEPTH)+1  1-based chronological lap index shown. 0 when showing live time.
- lap_count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- full  out  1  lap_count==DEPTH.
- recall_active  out  1  high in RECALL.

Behaviour:
- Reset (rstn=0 at posedge):
  - disp_time=0, lap_num=0, lap_count=0, full=0, recall_active=0.
  - wr_ptr=0, display FSM=LIVE.
  - prev_next_n=0, so a button held low through reset does not fire.
  - Buffer contents are don't-care.
- Browse edge: next_edge = !next_n && prev_next_n. prev_next_n <= next_n every cycle.
- Clear: state_i==INIT forces wr_ptr=0, lap_count=0, FSM=LIVE, lap_num=0. It has highest priority over every other event in the same cycle.
- Capture: on lap_en (and not INIT):
  - mem[wr_ptr] <= time_i and wr_ptr <= wr_ptr+1 mod DEPTH.
  - lap_count increments and saturates at DEPTH. When full, the oldest entry is overwritten.
- Oldest physical address = full ? wr_ptr : 0. Chronological index k (1..lap_count) maps to address (oldest+k-1) mod DEPTH.
- Display FSM states LIVE, HOLD, RECALL. disp_time is registered and updates one cycle after the selected source.
- LIVE:
  - disp_time<=time_i, lap_num=0.
  - lap_en → HOLD: hold_val<=time_i, hold_cnt<=HOLD_CYCLES-1, lap_num<=new lap_count.
- HOLD:
  - disp_time<=hold_val; hold_cnt decrements.
  - Exits to LIVE in the cycle hold_cnt==0, so total hold is HOLD_CYCLES cycles.
  - lap_en in HOLD recaptures, reloads hold_cnt and updates lap_num, staying in HOLD.
- Entering RECALL: from LIVE or HOLD, when state_i==STOP && next_edge && lap_count>0 → RECALL with lap_num<=lap_count (newest entry).
- RECALL:
  - disp_time<=mem[addr(lap_num)].
  - next_edge: lap_num<=lap_num-1. When lap_num==1, wraps to lap_count.
  - state_i != STOP → LIVE with lap_num<=0. RUN resumes live display; INIT also clears the buffer.
- Ignored browse edges:
  - next_edge while state_i != STOP has no effect.
  - next_edge with lap_count==0 has no effect; the FSM stays in its current state.
- Simultaneous events:
  - lap_en and next_edge in the same cycle: capture wins and next_edge is dropped. lap_en is only legal in RUN, so browsing is impossible anyway.
- Reset mid-HOLD or mid-RECALL returns all state to reset values within one cycle.

Optional Feature:
- Macro LAP_SPLIT_EN.
- Defined:
  - The buffer and hold_val store the split, time_i - last_cap, modulo 2^TIME_W.
  - last_cap is a register updated to time_i on every capture. It resets to 0 and is cleared to 0 on INIT.
- Undefined: cumulative time_i is stored. No last_cap register exists.

Decomposition:
- Shared package stopwatch_pkg holds:
  - the 2-bit controller state enum (INIT, RUN, STOP, LAP) with explicit encodings 0..3;
  - the display FSM enum (LIVE, HOLD, RECALL);
  - localparam PTR_W=$clog2(DEPTH).
- One sub-module, lap_buffer: storage array, wr_ptr, lap_count/full saturation, clear, and chronological→physical address mapping with combinational read.
- lap_recall_ctrl contains the edge detector, display FSM, hold counter and output registers.

Test Plan:
- Setup: HOLD_CYCLES=4 for all scenarios.
- Capture and hold: RUN, time_i=1234, lap_en pulse → disp_time=1234 and lap_num=1 for exactly 4 cycles, then disp_time tracks time_i one cycle late; lap_count=1.
- Overflow: 10 captures of values 1..10 into DEPTH=8 → full=1, lap_count=8; recall of index 1 shows 3 and index 8 shows 10.
- Browse wrap: STOP with 3 laps (100, 200, 300), next_n falling edges ×4 → disp_time 300, 200, 100, 300; lap_num 3, 2, 1, 3.
- Guarding: next_n falling edge in RUN, or in STOP with lap_count=0 → FSM stays LIVE, lap_num=0. next_n held low through reset then released → no RECALL.
- Exit and clear: in RECALL, state_i→RUN → LIVE next cycle. state_i→INIT → lap_count=0, full=0. lap_en and INIT in the same cycle → no capture.
- LAP_SPLIT_EN: captures at 500 then 1200 → stored 500 and 700. After INIT, a capture at 300 stores 300.
